// File: rtl/id_ex_stage_if.sv
// Bundle for the ID/EX pipeline register: decode inputs, forwarding taps,
// hazard-unit controls and the ALU-facing outputs.
interface id_ex_stage_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int CW     = 4,
  parameter int SCNT_W = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [DW-1:0]     id_rs_data_i;
  logic [DW-1:0]     id_rt_data_i;
  logic [DW-1:0]     id_imm_i;
  logic [AW-1:0]     id_rs_addr_i;
  logic [AW-1:0]     id_rt_addr_i;
  logic [AW-1:0]     id_wr_addr_i;
  logic [CW-1:0]     id_alu_ctrl_i;
  logic              id_alu_src_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic              id_mem_write_i;
  logic              exmem_reg_write_i;
  logic [AW-1:0]     exmem_wr_addr_i;
  logic [DW-1:0]     exmem_result_i;
  logic              memwb_reg_write_i;
  logic [AW-1:0]     memwb_wr_addr_i;
  logic [DW-1:0]     memwb_result_i;
  logic              ex_valid_o;
  logic [DW-1:0]     ex_src1_o;
  logic [DW-1:0]     ex_src2_o;
  logic [CW-1:0]     ex_alu_ctrl_o;
  logic [DW-1:0]     ex_store_data_o;
  logic [AW-1:0]     ex_wr_addr_o;
  logic              ex_reg_write_o;
  logic              ex_mem_read_o;
  logic              ex_mem_write_o;
  logic              load_use_o;
  logic [SCNT_W-1:0] stall_cnt_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_addr_i, id_rt_addr_i, id_wr_addr_i, id_alu_ctrl_i, id_alu_src_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i,
           exmem_reg_write_i, exmem_wr_addr_i, exmem_result_i,
           memwb_reg_write_i, memwb_wr_addr_i, memwb_result_i,
    input  ex_valid_o, ex_src1_o, ex_src2_o, ex_alu_ctrl_o, ex_store_data_o,
           ex_wr_addr_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           load_use_o, stall_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_addr_i, id_rt_addr_i, id_wr_addr_i, id_alu_ctrl_i, id_alu_src_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i,
           exmem_reg_write_i, exmem_wr_addr_i, exmem_result_i,
           memwb_reg_write_i, memwb_wr_addr_i, memwb_result_i,
    output ex_valid_o, ex_src1_o, ex_src2_o, ex_alu_ctrl_o, ex_store_data_o,
           ex_wr_addr_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           load_use_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use detection and a
// saturating stall counter. Define IDEX_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int CW     = 4,
  parameter int SCNT_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  id_ex_stage_if.slave   bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] alu_ctrl;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [DW-1:0]     rs_fwd, rt_fwd;
  logic              reg_write_v, mem_read_v, mem_write_v;
  logic              ex_dest_match;
  logic              hazard_src;

  // Flush beats stall beats load; a flush+stall cycle is not counted as a stall.
  always_comb begin
    stage_d     = stage_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush_i) begin
      stage_d = '0;
    end else if (bus.stall_i) begin
      if (stall_cnt_q != {SCNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + SCNT_W'(1);
      end
    end else begin
      stage_d.valid     = bus.id_valid_i;
      stage_d.rs_data   = bus.id_rs_data_i;
      stage_d.rt_data   = bus.id_rt_data_i;
      stage_d.imm       = bus.id_imm_i;
      stage_d.rs_addr   = bus.id_rs_addr_i;
      stage_d.rt_addr   = bus.id_rt_addr_i;
      stage_d.wr_addr   = bus.id_wr_addr_i;
      stage_d.alu_ctrl  = bus.id_alu_ctrl_i;
      stage_d.alu_src   = bus.id_alu_src_i;
      stage_d.reg_write = bus.id_reg_write_i;
      stage_d.mem_read  = bus.id_mem_read_i;
      stage_d.mem_write = bus.id_mem_write_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef IDEX_FWD_EN
  logic exmem_hit_rs, exmem_hit_rt, memwb_hit_rs, memwb_hit_rt;

  // EX/MEM is the younger producer, so it takes precedence; $0 is never forwarded.
  always_comb begin
    exmem_hit_rs = bus.exmem_reg_write_i && (bus.exmem_wr_addr_i != '0) &&
                   (bus.exmem_wr_addr_i == stage_q.rs_addr);
    exmem_hit_rt = bus.exmem_reg_write_i && (bus.exmem_wr_addr_i != '0) &&
                   (bus.exmem_wr_addr_i == stage_q.rt_addr);
    memwb_hit_rs = bus.memwb_reg_write_i && (bus.memwb_wr_addr_i != '0) &&
                   (bus.memwb_wr_addr_i == stage_q.rs_addr);
    memwb_hit_rt = bus.memwb_reg_write_i && (bus.memwb_wr_addr_i != '0) &&
                   (bus.memwb_wr_addr_i == stage_q.rt_addr);
    rs_fwd = stage_q.rs_data;
    rt_fwd = stage_q.rt_data;
    if (exmem_hit_rs) begin
      rs_fwd = bus.exmem_result_i;
    end else if (memwb_hit_rs) begin
      rs_fwd = bus.memwb_result_i;
    end
    if (exmem_hit_rt) begin
      rt_fwd = bus.exmem_result_i;
    end else if (memwb_hit_rt) begin
      rt_fwd = bus.memwb_result_i;
    end
  end
`else
  always_comb begin
    rs_fwd = stage_q.rs_data;
    rt_fwd = stage_q.rt_data;
  end
`endif

  always_comb begin
    reg_write_v = stage_q.reg_write & stage_q.valid;
    mem_read_v  = stage_q.mem_read  & stage_q.valid;
    mem_write_v = stage_q.mem_write & stage_q.valid;
  end

  // Without forwarding every RAW on the EX destination must stall, not just loads.
  always_comb begin
    ex_dest_match = (stage_q.wr_addr != '0) &&
                    ((stage_q.wr_addr == bus.id_rs_addr_i) ||
                     (stage_q.wr_addr == bus.id_rt_addr_i));
`ifdef IDEX_FWD_EN
    hazard_src = mem_read_v;
`else
    hazard_src = mem_read_v | reg_write_v;
`endif
  end

  assign bus.ex_valid_o      = stage_q.valid;
  assign bus.ex_src1_o       = rs_fwd;
  assign bus.ex_src2_o       = stage_q.alu_src ? stage_q.imm : rt_fwd;
  assign bus.ex_alu_ctrl_o   = stage_q.alu_ctrl;
  assign bus.ex_store_data_o = rt_fwd;
  assign bus.ex_wr_addr_o    = stage_q.wr_addr;
  assign bus.ex_reg_write_o  = reg_write_v;
  assign bus.ex_mem_read_o   = mem_read_v;
  assign bus.ex_mem_write_o  = mem_write_v;
  assign bus.load_use_o      = hazard_src & ex_dest_match & bus.id_valid_i;
  assign bus.stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the
// IDEX_FWD_EN setting the bench is compiled with.
module tb_id_ex_stage;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checkCount = 0;
  int   failCount  = 0;

  id_ex_stage_if #(.DW(32), .AW(5), .CW(4), .SCNT_W(16)) bus ();
  id_ex_stage_if #(.DW(32), .AW(5), .CW(4), .SCNT_W(2))  satBus ();

  id_ex_stage #(.DW(32), .AW(5), .CW(4), .SCNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  id_ex_stage #(.DW(32), .AW(5), .CW(4), .SCNT_W(2)) satDut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (satBus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rsAddr,
                               input logic [31:0] rsData, input logic [4:0] rtAddr,
                               input logic [31:0] rtData, input logic [31:0] imm,
                               input logic [4:0] wrAddr, input logic [3:0] ctrl,
                               input logic aluSrc, input logic regWrite,
                               input logic memRead, input logic memWrite);
    bus.id_valid_i     = valid;
    bus.id_rs_addr_i   = rsAddr;
    bus.id_rs_data_i   = rsData;
    bus.id_rt_addr_i   = rtAddr;
    bus.id_rt_data_i   = rtData;
    bus.id_imm_i       = imm;
    bus.id_wr_addr_i   = wrAddr;
    bus.id_alu_ctrl_i  = ctrl;
    bus.id_alu_src_i   = aluSrc;
    bus.id_reg_write_i = regWrite;
    bus.id_mem_read_i  = memRead;
    bus.id_mem_write_i = memWrite;
  endtask

  task automatic applyForward(input logic exWe, input logic [4:0] exAddr,
                              input logic [31:0] exRes, input logic wbWe,
                              input logic [4:0] wbAddr, input logic [31:0] wbRes);
    bus.exmem_reg_write_i = exWe;
    bus.exmem_wr_addr_i   = exAddr;
    bus.exmem_result_i    = exRes;
    bus.memwb_reg_write_i = wbWe;
    bus.memwb_wr_addr_i   = wbAddr;
    bus.memwb_result_i    = wbRes;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic fwdOn;
`ifdef IDEX_FWD_EN
    fwdOn = 1'b1;
`else
    fwdOn = 1'b0;
`endif
    rst_i = 1'b1;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    satBus.stall_i = 1'b0;
    satBus.flush_i = 1'b0;
    satBus.id_valid_i = 1'b0;     satBus.id_rs_data_i = '0;   satBus.id_rt_data_i = '0;
    satBus.id_imm_i = '0;         satBus.id_rs_addr_i = '0;   satBus.id_rt_addr_i = '0;
    satBus.id_wr_addr_i = '0;     satBus.id_alu_ctrl_i = '0;  satBus.id_alu_src_i = 1'b0;
    satBus.id_reg_write_i = 1'b0; satBus.id_mem_read_i = 1'b0; satBus.id_mem_write_i = 1'b0;
    satBus.exmem_reg_write_i = 1'b0; satBus.exmem_wr_addr_i = '0; satBus.exmem_result_i = '0;
    satBus.memwb_reg_write_i = 1'b0; satBus.memwb_wr_addr_i = '0; satBus.memwb_result_i = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    applyForward(0, 0, 0, 0, 0, 0);
    #11;
    checkOutput("reset_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    checkOutput("reset_ctrl", {28'd0, bus.ex_alu_ctrl_o}, 32'd0);
    checkOutput("reset_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic capture with no forwarding matches
    applyStimulus(1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd9, 4'b0010, 0, 1, 0, 0);
    stepClock();
    checkOutput("basic_src1", bus.ex_src1_o, 32'd5);
    checkOutput("basic_src2", bus.ex_src2_o, 32'd7);
    checkOutput("basic_ctrl", {28'd0, bus.ex_alu_ctrl_o}, 32'h2);
    checkOutput("basic_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    checkOutput("basic_regwr", {31'd0, bus.ex_reg_write_o}, 32'd1);

    // Forwarding priority on rs
    applyStimulus(1, 5'd3, 32'h99, 5'd4, 32'h55, 32'd0, 5'd10, 4'b0110, 0, 1, 0, 0);
    stepClock();
    applyForward(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    checkOutput("fwd_exmem", bus.ex_src1_o, fwdOn ? 32'h11 : 32'h99);
    checkOutput("fwd_rt_none", bus.ex_src2_o, 32'h55);
    applyForward(0, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    checkOutput("fwd_memwb", bus.ex_src1_o, fwdOn ? 32'h22 : 32'h99);
    applyStimulus(1, 5'd0, 32'h77, 5'd4, 32'h55, 32'd0, 5'd10, 4'b0000, 0, 1, 0, 0);
    stepClock();
    applyForward(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    checkOutput("fwd_reg0", bus.ex_src1_o, 32'h77);

    // Immediate operand with forwarded store data
    applyForward(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd1, 32'd1, 5'd6, 32'h33, 32'hFFFF_FFFC, 5'd0, 4'b0010, 1, 0, 0, 1);
    stepClock();
    applyForward(1, 5'd6, 32'h44, 0, 5'd0, 32'h0);
    checkOutput("imm_src2", bus.ex_src2_o, 32'hFFFF_FFFC);
    checkOutput("store_data", bus.ex_store_data_o, fwdOn ? 32'h44 : 32'h33);
    checkOutput("store_memwr", {31'd0, bus.ex_mem_write_o}, 32'd1);
    applyForward(0, 0, 0, 0, 0, 0);

    // Load-use detection, stall hold and flush bubble
    applyStimulus(1, 5'd1, 32'd100, 5'd2, 32'd0, 32'd4, 5'd8, 4'b0010, 1, 1, 1, 0);
    stepClock();
    applyStimulus(1, 5'd8, 32'd0, 5'd2, 32'd0, 32'd0, 5'd11, 4'b0010, 0, 1, 0, 0);
    #1;
    checkOutput("lu_hit", {31'd0, bus.load_use_o}, 32'd1);
    bus.id_valid_i = 1'b0;
    #1;
    checkOutput("lu_idle", {31'd0, bus.load_use_o}, 32'd0);
    bus.id_valid_i = 1'b1;
    bus.id_rs_addr_i = 5'd5;
    #1;
    checkOutput("lu_nomatch", {31'd0, bus.load_use_o}, 32'd0);
    bus.id_rs_addr_i = 5'd8;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) stepClock();
    bus.stall_i = 1'b0;
    #1;
    checkOutput("stall_cnt3", {16'd0, bus.stall_cnt_o}, 32'd3);
    checkOutput("stall_hold_wr", {27'd0, bus.ex_wr_addr_o}, 32'd8);
    checkOutput("stall_hold_rd", {31'd0, bus.ex_mem_read_o}, 32'd1);
    checkOutput("stall_hold_src1", bus.ex_src1_o, 32'd100);
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    stepClock();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    checkOutput("flush_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    checkOutput("flush_regwr", {31'd0, bus.ex_reg_write_o}, 32'd0);
    checkOutput("flush_cnt", {16'd0, bus.stall_cnt_o}, 32'd3);
    checkOutput("flush_lu", {31'd0, bus.load_use_o}, 32'd0);

    // ALU producer in EX: a hazard only when forwarding is absent
    applyStimulus(1, 5'd1, 32'd2, 5'd2, 32'd3, 32'd0, 5'd9, 4'b0001, 0, 1, 0, 0);
    stepClock();
    applyStimulus(1, 5'd9, 32'd0, 5'd2, 32'd0, 32'd0, 5'd12, 4'b0010, 0, 1, 0, 0);
    #1;
    checkOutput("alu_raw_lu", {31'd0, bus.load_use_o}, fwdOn ? 32'd0 : 32'd1);

    // Asynchronous reset with a live instruction held in EX
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("arst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    checkOutput("arst_regwr", {31'd0, bus.ex_reg_write_o}, 32'd0);
    checkOutput("arst_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);
    checkOutput("arst_src1", bus.ex_src1_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Narrow counter saturates at all-ones
    satBus.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) stepClock();
    checkOutput("sat_cnt2", {30'd0, satBus.stall_cnt_o}, 32'd2);
    for (int i = 0; i < 3; i++) stepClock();
    satBus.stall_i = 1'b0;
    checkOutput("sat_cnt_max", {30'd0, satBus.stall_cnt_o}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the ALU.
- Captures decoded operands, immediate, ALU control code and downstream control bits.
- Resolves register-file data hazards by forwarding from the EX/MEM and MEM/WB results. It then presents src1/src2/ctrl directly to the ALU.
- Detects load-use hazards and counts stall cycles for performance debug.

Parameters:
- DW, 32, datapath width (ALU operand width)
- AW, 5, register address width
- CW, 4, ALU control code width
- SCNT_W, 16, width of saturating stall-cycle counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- stall_i  in  1  hold current contents, insert nothing
- flush_i  in  1  squash: next cycle holds a bubble
- id_valid_i  in  1  decode stage presents a valid instruction
- id_rs_data_i  in  DW  register file read data, rs
- id_rt_data_i  in  DW  register file read data, rt
- id_imm_i  in  DW  sign-extended immediate
- id_rs_addr_i  in  AW  rs index
- id_rt_addr_i  in  AW  rt index
- id_wr_addr_i  in  AW  destination index (already muxed rd/rt)
- id_alu_ctrl_i  in  CW  ALU operation code (0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 0101 nor, 1000 mul)
- id_alu_src_i  in  1  1: src2 = immediate
- id_reg_write_i  in  1  write-back enable
- id_mem_read_i  in  1  load
- id_mem_write_i  in  1  store
- exmem_reg_write_i  in  1  EX/MEM write-back enable
- exmem_wr_addr_i  in  AW  EX/MEM destination
- exmem_result_i  in  DW  EX/MEM ALU result
- memwb_reg_write_i  in  1  MEM/WB write-back enable
- memwb_wr_addr_i  in  AW  MEM/WB destination
- memwb_result_i  in  DW  MEM/WB write-back data
- ex_valid_o  out  1  stage holds a real instruction
- ex_src1_o  out  DW  ALU src1
- ex_src2_o  out  DW  ALU src2
- ex_alu_ctrl_o  out  CW  ALU ctrl
- ex_store_data_o  out  DW  forwarded rt value for stores
- ex_wr_addr_o  out  AW  destination index
- ex_reg_write_o / ex_mem_read_o / ex_mem_write_o  out  1 each  gated by ex_valid_o
- load_use_o  out  1  combinational hazard request to hazard unit
- stall_cnt_o  out  SCNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_i=1):
  - all registered fields cleared; ex_valid_o=0, all control outputs 0, ex_alu_ctrl_o=0000, stall_cnt_o=0.
  - Reset mid-operation discards the held instruction immediately; no write-back is issued.
- Capture on clk_i rising edge, priority flush_i > stall_i > load:
  - flush_i=1: valid cleared, control bits cleared, data fields don't-care (cleared in RTL).
  - stall_i=1 (no flush): all fields hold; stall_cnt_o increments, saturating at all-ones.
  - otherwise: capture all id_* inputs; valid = id_valid_i.
- Latency: one cycle from id_* to ex_* outputs.
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o = registered bit AND valid. A bubble never writes.
- Forwarding is combinational on registered rs/rt indices, evaluated separately per operand:
  - if exmem_reg_write_i and exmem_wr_addr_i≠0 and exmem_wr_addr_i==reg rs: use exmem_result_i;
  - else if the same conditions hold for memwb: use memwb_result_i;
  - else use the registered register-file data.
  - EX/MEM wins when both match (youngest value).
  - Register 0 is never forwarded; it always reads the registered data.
- ex_src1_o = forwarded rs.
- ex_src2_o = alu_src ? registered imm : forwarded rt.
- ex_store_data_o = forwarded rt, regardless of alu_src.
- load_use_o = ex_valid_o & ex_mem_read_o & (ex_wr_addr_o≠0) & (ex_wr_addr_o==id_rs_addr_i | ex_wr_addr_o==id_rt_addr_i) & id_valid_i.
- Stall and flush are driven by the external hazard unit; this block does not self-stall.

Optional Feature:
- Macro IDEX_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - forwarding muxes removed; src1/store data come straight from registered register-file data.
  - load_use_o also asserts for any EX-stage reg_write destination match, not only loads, so the hazard unit stalls on all RAW hazards.

Test Plan:
- Reset: hold rst_i=1 mid-stream with valid instruction latched -> ex_valid_o=0, all controls 0, stall_cnt_o=0 asynchronously, before the next clock edge.
- Basic: id rs_data=5, rt_data=7, ctrl=0010, alu_src=0, no forwarding matches -> next cycle ex_src1_o=5, ex_src2_o=7, ex_alu_ctrl_o=0010, ex_valid_o=1.
- Forward priority: reg rs=3, exmem wr=3 result=0x11, memwb wr=3 result=0x22, both write enables 1 -> ex_src1_o=0x11. With exmem_reg_write_i=0 -> 0x22. With rs=0 -> registered data.
- Immediate/store: alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x44, mem_write=1 -> ex_src2_o=0xFFFFFFFC, ex_store_data_o=0x44.
- Load-use: EX holds lw to $8; ID presents rs=8, id_valid_i=1 -> load_use_o=1. Drive stall_i 3 cycles -> contents held, stall_cnt_o=3. Drive flush_i and stall_i together -> bubble inserted, counter unchanged.
- Saturation: SCNT_W=2, stall 5 cycles -> stall_cnt_o=3.
